// File: rtl/shift_add_mult_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mult_pkg                                                         |
// | Brief   : Shared constants and FSM state type for the 4x4 sequential       |
// |           shift-and-add multiplier.                                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mult_pkg;

  localparam int N     = 4;  // operand width; product is 2*N bits
  localparam int CNT_W = 2;  // iteration counter width, clog2(N)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : shift_add_mult_seq_if                                          |
// | Brief     : Operand/product handshake bundle between the operand source    |
// |             (master) and the multiplier (slave).                           |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface shift_add_mult_seq_if;
  import mult_pkg::*;

  logic               start;
  logic [N-1:0]       a;
  logic [N-1:0]       b;
  logic               busy;
  logic               done;
  logic [2*N-1:0]     p;

  modport master (output start, a, b, input  busy, done, p);
  modport slave  (input  start, a, b, output busy, done, p);

endinterface : shift_add_mult_seq_if
`default_nettype wire

// File: rtl/shift_add_mult_seq_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : adder                                                             |
// | Brief  : 8-bit ripple-carry adder built from a chain of full-adder cells.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module adder (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  input  wire logic       cin,
  output logic      [7:0] sum,
  output logic            cout
);

  logic [8:0] w_carry;

  assign w_carry[0] = cin;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[8];

endmodule : adder
`default_nettype wire

// File: rtl/shift_add_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : shift_add_mult_seq                                                |
// | Brief  : Sequential 4x4 unsigned shift-and-add multiplier. One partial     |
// |          product per cycle is accumulated through the ripple adder; the    |
// |          result is ready N cycles after an accepted start.                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module shift_add_mult_seq
  import mult_pkg::*;
#(
  parameter int N     = mult_pkg::N,
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input wire logic               clk,
  input wire logic               rst_n,
  shift_add_mult_seq_if.slave    bus
);

  localparam int P_W = 2 * N;

  // The adder is hard-wired at 8 bits, so only a 4-bit operand width fits.
  if (N != 4 || CNT_W != 2) begin : g_bad_width
    $error("shift_add_mult_seq: N must be 4 and CNT_W must be 2");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;
  logic               w_done;

  logic [P_W-1:0]     r_mcand;
  logic [N-1:0]       r_mplier;
  logic [P_W-1:0]     r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [P_W-1:0]     w_sum;
  logic               w_cout_unused;

  // Sole arithmetic unit; 15*15 fits in 8 bits so the carry-out never matters.
  adder u_adder (
    .a    (r_acc),
    .b    (r_mcand),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout_unused)
  );

  // State register; reset from any state returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; unused encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = IDLE;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = bus.start ? CALC : IDLE;
      CALC: begin
        w_busy      = 1'b1;
        w_state_nxt = (r_cnt == CNT_W'(N - 1)) ? DONE : CALC;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then one shift-and-add step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{(P_W - N){1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          if (r_mplier[0]) r_acc <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.p    = r_acc;

endmodule : shift_add_mult_seq
`default_nettype wire

// File: tb/tb_shift_add_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_shift_add_mult_seq                                             |
// | Brief  : Scoreboard bench for the sequential shift-and-add multiplier.     |
// |          Stimulus pushes expected products and due cycles; a monitor pops  |
// |          and compares on every done pulse and checks p holds in IDLE.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_shift_add_mult_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fails;
  int   done_cnt;
  bit   rst_seen;
  logic [7:0] last_p;
  logic [7:0] exp_q[$];
  int         due_q[$];

  shift_add_mult_seq_if bus ();

  shift_add_mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter and reset observation, both taken at the active edge.
  always @(posedge clk) begin
    cyc++;
    rst_seen = !rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on each done; p must hold while idle.
  always @(negedge clk) begin
    if (rst_seen) begin
      last_p = 8'd0;
    end else if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_done: got done with p=%0d, expected no done", bus.p);
      end else begin
        chk("product", {24'd0, bus.p}, {24'd0, exp_q.pop_front()});
        chk("latency", cyc, due_q.pop_front());
      end
      last_p = bus.p;
    end else if (bus.busy === 1'b0) begin
      chk("p_hold", {24'd0, bus.p}, {24'd0, last_p});
    end
  end

  // Called at a negedge; waits for IDLE, presents one start, returns one cycle later.
  task automatic issue(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp,
                       input bit push);
    int guard = 0;
    while (bus.busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("issue_timeout", 32'd1, 32'd0);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    if (push) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 1 + 4);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct { logic [3:0] a; logic [3:0] b; logic [7:0] p; } vec_t;
  vec_t stream[4];

  initial begin
    int d0;
    cyc = 0; n_checks = 0; n_fails = 0; done_cnt = 0; last_p = 8'd0; rst_seen = 1'b1;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
    stream[0] = '{4'd2,  4'd3, 8'd6};
    stream[1] = '{4'd15, 4'd1, 8'd15};
    stream[2] = '{4'd4,  4'd4, 8'd16};
    stream[3] = '{4'd11, 4'd7, 8'd77};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_p",    {24'd0, bus.p}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Largest operands, then mixed and zero operands
    issue(4'd15, 4'd15, 8'd225, 1'b1); drain();
    issue(4'd13, 4'd11, 8'd143, 1'b1); drain();
    issue(4'd0,  4'd9,  8'd0,   1'b1); drain();

    // Start during CALC is ignored; exactly one done
    d0 = done_cnt;
    issue(4'd7, 4'd6, 8'd42, 1'b1);
    bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
    chk("busy_in_calc", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    chk("single_done", done_cnt - d0, 32'd1);

    // Reset at the 2nd CALC edge aborts without a done
    issue(4'd9, 4'd9, 8'd81, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_p",    {24'd0, bus.p}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (8) @(negedge clk);
    issue(4'd3, 4'd5, 8'd15, 1'b1); drain();

    // start held high: one accept every 6 cycles
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a = stream[i].a;
      bus.b = stream[i].b;
      exp_q.push_back(stream[i].p);
      due_q.push_back(cyc + 1 + 4);
      repeat (6) @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    // Full operand sweep against the reference product
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        issue(4'(ia), 4'(ib), 8'(ia * ib), 1'b1);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_shift_add_mult_seq
`default_nettype wire
